maxpool2d_stream: RTL

- Streaming 2x2, stride-2 max-pool for multi-channel feature maps. Replaces the pass-through pool stage between relu and linear.
- Consumes one raster-ordered pixel (all channels packed) per input_valid beat.
- Uses a half-row line buffer to emit one pooled pixel per 2x2 window.
- Channel count, data width, image size and signedness are parameters.

---
 rtl/maxpool2d_stream_if.sv | 34 +++
 rtl/maxpool2d_stream.sv | 94 +++++++++
 2 files changed

// File: rtl/maxpool2d_stream_if.sv
// Stream bundle for the 2x2 max-pool stage: packed input pixels in, pooled pixels
// plus their pooled coordinates out. Neither direction has backpressure.
interface maxpool2d_stream_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int IMG_W    = 6,
    parameter int IMG_H    = 6
);
    localparam int PW     = CHANNELS * DATA_W;
    localparam int OCOL_W = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int OROW_W = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

    // A beat transfers on every cycle where input_valid is high, and a pooled
    // pixel on every cycle where output_valid is high. There is no ready signal,
    // so the receiver must take every valid cycle.
    logic              sof;
    logic [PW-1:0]     input_data;
    logic              input_valid;
    logic [PW-1:0]     output_data;
    logic              output_valid;
    logic [OCOL_W-1:0] out_col;
    logic [OROW_W-1:0] out_row;
    logic              frame_done;

    modport master (
        output sof, input_data, input_valid,
        input  output_data, output_valid, out_col, out_row, frame_done
    );

    modport slave (
        input  sof, input_data, input_valid,
        output output_data, output_valid, out_col, out_row, frame_done
    );
endinterface

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 max-pool: a pair register reduces each row pair of columns,
// and a half-row line buffer holds even-row pairs until the matching odd row arrives.
module maxpool2d_stream #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int IMG_W    = 6,
    parameter int IMG_H    = 6,
    parameter int SIGNED   = 0
) (
    input logic               clk,
    input logic               reset,
    maxpool2d_stream_if.slave bus
);
    localparam int PW     = CHANNELS * DATA_W;
    localparam int HALF_W = IMG_W / 2;
    localparam int HALF_H = IMG_H / 2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int OCOL_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int OROW_W = (HALF_H > 1) ? $clog2(HALF_H) : 1;

    logic [COL_W-1:0]  col, cur_col;
    logic [ROW_W-1:0]  row, cur_row;
    logic [PW-1:0]     hmax, pair, result, lb_rd;
    logic [PW-1:0]     linebuf [HALF_W];
    logic [OCOL_W-1:0] lb_idx;
    logic [OROW_W-1:0] pool_row;
    logic              col_last, row_last;

    function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
        else             return (a > b) ? a : b;
    endfunction

    // sof forces the current beat to position (0,0) without waiting for counters.
    always_comb begin
        cur_col  = bus.sof ? '0 : col;
        cur_row  = bus.sof ? '0 : row;
        lb_idx   = OCOL_W'(cur_col >> 1);
        pool_row = OROW_W'(cur_row >> 1);
        col_last = (cur_col == COL_W'(IMG_W - 1));
        row_last = (cur_row == ROW_W'(IMG_H - 1));
        lb_rd    = '0;
        for (int i = 0; i < HALF_W; i++) begin
            if (lb_idx == OCOL_W'(i)) lb_rd = linebuf[i];
        end
        pair   = '0;
        result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pair[c*DATA_W +: DATA_W]   = vmax(hmax[c*DATA_W +: DATA_W],
                                              bus.input_data[c*DATA_W +: DATA_W]);
            result[c*DATA_W +: DATA_W] = vmax(lb_rd[c*DATA_W +: DATA_W],
                                              pair[c*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col              <= '0;
            row              <= '0;
            hmax             <= '0;
            for (int i = 0; i < HALF_W; i++) linebuf[i] <= '0;
            bus.output_data  <= '0;
            bus.output_valid <= 1'b0;
            bus.out_col      <= '0;
            bus.out_row      <= '0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.output_valid <= 1'b0;
            bus.frame_done   <= 1'b0;
            if (bus.input_valid) begin
                if (!cur_col[0]) begin
                    hmax <= bus.input_data;
                end else if (!cur_row[0]) begin
                    for (int i = 0; i < HALF_W; i++) begin
                        if (lb_idx == OCOL_W'(i)) linebuf[i] <= pair;
                    end
                end else begin
                    // Odd column of an odd row always closes a complete window;
                    // a trailing odd column or row never reaches this branch.
                    bus.output_valid <= 1'b1;
                    bus.output_data  <= result;
                    bus.out_col      <= lb_idx;
                    bus.out_row      <= pool_row;
                    bus.frame_done   <= (lb_idx == OCOL_W'(HALF_W - 1)) &&
                                        (pool_row == OROW_W'(HALF_H - 1));
                end
                col <= col_last ? '0 : cur_col + 1'b1;
                row <= col_last ? (row_last ? '0 : cur_row + 1'b1) : cur_row;
            end
        end
    end
endmodule
